fifo_uart_tx: RTL and testbench



---
 rtl/fifo_pkg.sv | 7 +
 rtl/fifo_uart_tx_if.sv | 9 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/fifo_uart_tx.sv | 119 +++++++++++
 tb/tb_fifo_uart_tx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO UART transmitter.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake: the transmitter (master) pops from the FIFO (slave).
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_pop;

    modport master (input fifo_empty, input fifo_rd_data, output fifo_pop);
    modport slave  (output fifo_empty, output fifo_rd_data, input fifo_pop);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high in the last cycle of each CLKS_PER_BIT period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // restart is asserted in the cycle the FSM changes state, so the new state starts at 0
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1-style UART frame.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 busy,
    output logic [7:0]           frames_sent
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [7:0]            frames_q, frames_d;
    logic                  tx_q, tx_d;
    logic                  pop_q, pop_d;
    logic                  busy_q, busy_d;
    logic                  tick, restart;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    // tx_d is the line level for the next cycle, so tx stays a plain flop output
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        frames_d = frames_q;
        tx_d     = tx_q;
        pop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (ena && !fifo.fifo_empty) begin
                    state_d = START;
                    shreg_d = fifo.fifo_rd_data;
                    pop_d   = 1'b1;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        state_d  = IDLE;
                        frames_d = frames_q + 8'd1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        restart = (state_d != state_q);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            frames_q <= 8'd0;
            tx_q     <= UART_IDLE_LEVEL;
            pop_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
            pop_q    <= pop_d;
            busy_q   <= busy_d;
        end
    end

    assign fifo.fifo_pop = pop_q;
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign frames_sent   = frames_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       tx, busy;
    logic [7:0] frames_sent;

    logic [7:0] mem [0:1023];
    int         wr = 0;
    int         rd = 0;
    int         pops = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fif ();

    assign fif.fifo_empty   = (rd == wr);
    assign fif.fifo_rd_data = mem[rd % 1024];

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .fifo       (fif.master),
        .tx         (tx),
        .busy       (busy),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fif.fifo_pop) begin
            pops <= pops + 1;
            if (rd != wr) rd <= rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr % 1024] = d;
        wr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pop", fif.fifo_pop, 0);
        chk("rst_frames", frames_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns the number of negedges waited before tx first reads low.
    task automatic wait_start(input string tag, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) chk({tag, "_timeout"}, 1, 0);
    endtask

    // Checks one full frame from the first low cycle; ends on the following idle cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit drop_ena,
                             output int waited);
        logic [9:0] exp_bits;
        int errs, extra_pops;
        exp_bits = {1'b1, d, 1'b0};
        errs = 0;
        extra_pops = 0;
        wait_start(tag, waited);
        chk({tag, "_pop_at_start"}, fif.fifo_pop, 1);
        chk({tag, "_busy"}, busy, 1);
        for (int k = 0; k < FRAME; k++) begin
            if (tx !== exp_bits[k / CPB]) errs++;
            if (k > 0 && fif.fifo_pop) extra_pops++;
            if (busy !== 1'b1) errs++;
            @(negedge clk);
            if (drop_ena && k == 1) ena = 1'b0;
        end
        chk({tag, "_bits"}, errs, 0);
        chk({tag, "_extra_pops"}, extra_pops, 0);
        chk({tag, "_idle_after"}, {busy, tx}, 2'b01);
    endtask

    initial begin
        int w, errs, p0;

        // reset state, then single byte 0xA5
        do_reset();
        ena = 1'b1;
        p0 = pops;
        push(8'hA5);
        run_frame("a5", 8'hA5, 1'b0, w);
        chk("a5_frames", frames_sent, 1);
        chk("a5_pops", pops - p0, 1);

        // back-to-back 0x00 then 0xFF with one idle cycle between frames
        do_reset();
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        run_frame("b0", 8'h00, 1'b0, w);
        run_frame("b1", 8'hFF, 1'b0, w);
        chk("b2b_gap", w, 1);
        chk("b2b_frames", frames_sent, 2);
        chk("b2b_pops", pops - p0, 2);

        // empty FIFO for 200 cycles
        errs = 0;
        p0 = pops;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fif.fifo_pop !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("empty_idle", errs, 0);
        chk("empty_pops", pops - p0, 0);

        // reset during the third data bit of 0xC3 (that bit is 0)
        push(8'hC3);
        wait_start("rst", w);
        repeat (14) @(negedge clk);
        chk("pre_rst_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx", tx, 1);
        chk("async_busy", busy, 0);
        chk("async_frames", frames_sent, 0);
        @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fif.fifo_pop !== 1'b0) errs++;
        end
        chk("post_rst_idle", errs, 0);

        // ena dropped during START of 0x3C; 0x55 waits until ena returns
        p0 = pops;
        push(8'h3C);
        push(8'h55);
        run_frame("e3c", 8'h3C, 1'b1, w);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fif.fifo_pop !== 1'b0) errs++;
            @(negedge clk);
        end
        chk("ena_low_idle", errs, 0);
        chk("ena_low_pops", pops - p0, 1);
        ena = 1'b1;
        run_frame("e55", 8'h55, 1'b0, w);
        chk("ena_start_lat", w, 1);
        chk("ena_frames", frames_sent, 2);

        // frames_sent wrap after 256 frames
        do_reset();
        p0 = pops;
        for (int i = 0; i < 256; i++) push(8'h00);
        w = 0;
        while (!(rd == wr && busy === 1'b0) && w < 12000) begin
            @(negedge clk);
            w++;
        end
        chk("wrap_done", w < 12000, 1);
        chk("wrap_frames", frames_sent, 0);
        chk("wrap_pops", pops - p0, 256);
        push(8'h00);
        run_frame("f257", 8'h00, 1'b0, w);
        chk("f257_frames", frames_sent, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
